// File: rtl/fdct_pkg.sv
// Shared constants and types for the column 1-D forward DCT.
// DCT_COEF[k][n] = round_half_away(4096 * 0.5 * c(k) * cos((2n+1)k*pi/16)).
package fdct_pkg;

    localparam int COEF_FRAC_DEF = 12;
    localparam int OUT_W_DEF     = 12;
    localparam int PIX_W         = 8;
    localparam int SHIFT_W       = 9;
    localparam int COEF_W        = 13;
    localparam int PROD_W        = SHIFT_W + COEF_W;
    localparam int ACC_W         = 23;

    typedef logic [PIX_W-1:0]            pix_col_t  [8];
    typedef logic signed [OUT_W_DEF-1:0] coef_col_t [8];

    localparam logic [0:7][0:7][COEF_W-1:0] DCT_COEF = '{
        '{ 13'sd1448,  13'sd1448,  13'sd1448,  13'sd1448,  13'sd1448,  13'sd1448,  13'sd1448,  13'sd1448},
        '{ 13'sd2009,  13'sd1703,  13'sd1138,  13'sd400,  -13'sd400,  -13'sd1138, -13'sd1703, -13'sd2009},
        '{ 13'sd1892,  13'sd784,  -13'sd784,  -13'sd1892, -13'sd1892, -13'sd784,   13'sd784,   13'sd1892},
        '{ 13'sd1703, -13'sd400,  -13'sd2009, -13'sd1138,  13'sd1138,  13'sd2009,  13'sd400,  -13'sd1703},
        '{ 13'sd1448, -13'sd1448, -13'sd1448,  13'sd1448,  13'sd1448, -13'sd1448, -13'sd1448,  13'sd1448},
        '{ 13'sd1138, -13'sd2009,  13'sd400,   13'sd1703, -13'sd1703, -13'sd400,   13'sd2009, -13'sd1138},
        '{ 13'sd784,  -13'sd1892,  13'sd1892, -13'sd784,  -13'sd784,   13'sd1892, -13'sd1892,  13'sd784},
        '{ 13'sd400,  -13'sd1138,  13'sd1703, -13'sd2009,  13'sd2009, -13'sd1703,  13'sd1138, -13'sd400}
    };

endpackage

// File: rtl/dct_dot8.sv
// One DCT output coefficient: 8 products (S2), sum (S3), round/saturate (S4).
// Each stage only loads when the data feeding it is valid, so the output holds across bubbles.
module dct_dot8
    import fdct_pkg::*;
#(
    parameter int COEF_FRAC = COEF_FRAC_DEF,
    parameter int OUT_W     = OUT_W_DEF,
    parameter logic [0:7][COEF_W-1:0] ROW = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic signed [SHIFT_W-1:0] s [8],
    input  logic [2:0]                en,
    output logic signed [OUT_W-1:0]   y
);

    localparam int RND_W = ACC_W + 1;
    localparam logic signed [RND_W-1:0] RND_HALF = RND_W'(2 ** (COEF_FRAC - 1));
    localparam logic signed [RND_W-1:0] SAT_MAX  = RND_W'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [RND_W-1:0] SAT_MIN  = RND_W'(-(2 ** (OUT_W - 1)));

    logic signed [PROD_W-1:0] prod_d [8];
    logic signed [PROD_W-1:0] prod_q [8];
    logic signed [ACC_W-1:0]  acc_d;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [RND_W-1:0]  rnd_s;
    logic signed [RND_W-1:0]  shr_s;
    logic signed [OUT_W-1:0]  y_d;
    logic signed [OUT_W-1:0]  y_q;

    always_comb begin
        for (int n = 0; n < 8; n++) begin
            if (en[0]) begin
                prod_d[n] = PROD_W'(s[n]) * PROD_W'($signed(ROW[n]));
            end else begin
                prod_d[n] = prod_q[n];
            end
        end

        acc_d = acc_q;
        if (en[1]) begin
            acc_d = '0;
            for (int n = 0; n < 8; n++) begin
                acc_d = acc_d + ACC_W'(prod_q[n]);
            end
        end else begin
            acc_d = acc_q;
        end

        // Arithmetic shift after adding half: ties round toward +inf.
        rnd_s = RND_W'(acc_q) + RND_HALF;
        shr_s = rnd_s >>> COEF_FRAC;
        y_d   = y_q;
        if (!en[2]) begin
            y_d = y_q;
        end else if (shr_s > SAT_MAX) begin
            y_d = {1'b0, {(OUT_W-1){1'b1}}};
        end else if (shr_s < SAT_MIN) begin
            y_d = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            y_d = OUT_W'(shr_s);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < 8; n++) begin
                prod_q[n] <= '0;
            end
            acc_q <= '0;
            y_q   <= '0;
        end else begin
            for (int n = 0; n < 8; n++) begin
                prod_q[n] <= prod_d[n];
            end
            acc_q <= acc_d;
            y_q   <= y_d;
        end
    end

    assign y = y_q;

endmodule

// File: rtl/col_dct_1d.sv
// Pipelined 8-point forward DCT over one pixel column per valid cycle, 4-cycle latency.
// Owns the level shift (S1), the valid/column-index pipeline and the column counter.
module col_dct_1d
    import fdct_pkg::*;
#(
    parameter int COEF_FRAC = COEF_FRAC_DEF,
    parameter int OUT_W     = OUT_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              din [7:0],
    input  logic                    din_valid,
    output logic signed [OUT_W-1:0] dout [7:0],
    output logic                    dout_valid,
    output logic [2:0]              col_idx,
    output logic                    blk_start
);

    logic signed [SHIFT_W-1:0] shift_d [8];
    logic signed [SHIFT_W-1:0] shift_q [8];
    logic [2:0] cnt_d;
    logic [2:0] cnt_q;
    logic [3:0] vld_d;
    logic [3:0] vld_q;
    logic [2:0] idx_d [4];
    logic [2:0] idx_q [4];
    logic       blk_start_d;
    logic       blk_start_q;

    always_comb begin
        for (int n = 0; n < 8; n++) begin
            if (din_valid) begin
                shift_d[n] = $signed({1'b0, din[n]}) - 9'sd128;
            end else begin
                shift_d[n] = shift_q[n];
            end
        end

        if (din_valid) begin
            cnt_d    = cnt_q + 3'd1;
            idx_d[0] = cnt_q;
        end else begin
            cnt_d    = cnt_q;
            idx_d[0] = idx_q[0];
        end

        // The column index rides with its data and holds with it across bubbles.
        vld_d = {vld_q[2:0], din_valid};
        for (int i = 1; i < 4; i++) begin
            if (vld_q[i-1]) begin
                idx_d[i] = idx_q[i-1];
            end else begin
                idx_d[i] = idx_q[i];
            end
        end

        blk_start_d = vld_d[3] && (idx_d[3] == 3'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < 8; n++) begin
                shift_q[n] <= '0;
            end
            for (int i = 0; i < 4; i++) begin
                idx_q[i] <= 3'd0;
            end
            cnt_q       <= 3'd0;
            vld_q       <= 4'd0;
            blk_start_q <= 1'b0;
        end else begin
            for (int n = 0; n < 8; n++) begin
                shift_q[n] <= shift_d[n];
            end
            for (int i = 0; i < 4; i++) begin
                idx_q[i] <= idx_d[i];
            end
            cnt_q       <= cnt_d;
            vld_q       <= vld_d;
            blk_start_q <= blk_start_d;
        end
    end

    for (genvar k = 0; k < 8; k++) begin : g_dot
        dct_dot8 #(
            .COEF_FRAC (COEF_FRAC),
            .OUT_W     (OUT_W),
            .ROW       (DCT_COEF[k])
        ) u_dot (
            .clk (clk),
            .rst (rst),
            .s   (shift_q),
            .en  (vld_q[2:0]),
            .y   (dout[k])
        );
    end

    assign dout_valid = vld_q[3];
    assign col_idx    = idx_q[3];
    assign blk_start  = blk_start_q;

endmodule

// File: tb/tb_col_dct_1d.sv
// Self-checking bench for col_dct_1d: a real-arithmetic DCT reference with a 4-deep latency
// history is compared against the DUT every cycle, plus hand-computed literal checks.
module tb_col_dct_1d;

    logic              clk = 1'b0;
    logic              rst;
    logic [7:0]        din [7:0];
    logic              din_valid;
    logic signed [11:0] dout [7:0];
    logic              dout_valid;
    logic [2:0]        col_idx;
    logic              blk_start;

    col_dct_1d dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .dout       (dout),
        .dout_valid (dout_valid),
        .col_idx    (col_idx),
        .blk_start  (blk_start)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int coef [8][8];
    int cyc = 0;

    int h_val [4];
    int h_idx [4];
    int h_dat [4][8];
    int m_cnt;
    int last_dat [8];

    int log_cyc [$];
    int log_idx [$];
    int log_blk [$];
    int log_d0  [$];
    int log_d1  [$];
    int log_nz  [$];
    int in_q    [$];

    int gap_pat [13] = '{1, 1, 1, 0, 0, 1, 0, 1, 1, 0, 0, 0, 1};
    int px [8];
    int y [8];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void build_coef();
        real pi, c, v;
        pi = 3.14159265358979;
        for (int k = 0; k < 8; k++) begin
            for (int n = 0; n < 8; n++) begin
                c = (k == 0) ? 1.0 / $sqrt(2.0) : 1.0;
                v = 4096.0 * 0.5 * c * $cos(real'((2 * n + 1) * k) * pi / 16.0);
                coef[k][n] = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
            end
        end
    endfunction

    function automatic int dct_k(input int p [8], input int k);
        int acc, r;
        acc = 0;
        for (int n = 0; n < 8; n++) begin
            acc += (p[n] - 128) * coef[k][n];
        end
        r = (acc + 2048) >>> 12;
        if (r > 2047) r = 2047;
        if (r < -2048) r = -2048;
        return r;
    endfunction

    // Reference state update at a rising edge, using the inputs the DUT just sampled.
    task automatic model_step();
        int p [8];
        cyc++;
        if (rst) begin
            for (int i = 0; i < 4; i++) h_val[i] = 0;
            for (int k = 0; k < 8; k++) last_dat[k] = 0;
            m_cnt = 0;
        end else begin
            for (int i = 3; i > 0; i--) begin
                h_val[i] = h_val[i-1];
                h_idx[i] = h_idx[i-1];
                for (int k = 0; k < 8; k++) h_dat[i][k] = h_dat[i-1][k];
            end
            for (int n = 0; n < 8; n++) p[n] = int'(din[n]);
            h_val[0] = int'(din_valid);
            h_idx[0] = m_cnt;
            for (int k = 0; k < 8; k++) h_dat[0][k] = dct_k(p, k);
            if (din_valid) m_cnt = (m_cnt + 1) % 8;
            if (h_val[3] != 0) begin
                for (int k = 0; k < 8; k++) last_dat[k] = h_dat[3][k];
            end
        end
    endtask

    task automatic compare();
        int nz;
        chk("dout_valid", int'(dout_valid), h_val[3]);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("dout[%0d]", k), int'(dout[k]), last_dat[k]);
        end
        chk("blk_start", int'(blk_start), (h_val[3] != 0 && h_idx[3] == 0) ? 1 : 0);
        if (h_val[3] != 0) chk("col_idx", int'(col_idx), h_idx[3]);
        if (dout_valid) begin
            nz = 0;
            for (int k = 1; k < 8; k++) if (dout[k] != 0) nz++;
            log_cyc.push_back(cyc);
            log_idx.push_back(int'(col_idx));
            log_blk.push_back(int'(blk_start));
            log_d0.push_back(int'(dout[0]));
            log_d1.push_back(int'(dout[1]));
            log_nz.push_back(nz);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic clear_log();
        log_cyc.delete(); log_idx.delete(); log_blk.delete();
        log_d0.delete(); log_d1.delete(); log_nz.delete(); in_q.delete();
    endtask

    task automatic set_col(input int v0, input int vrest);
        din[0] = 8'(v0);
        for (int n = 1; n < 8; n++) din[n] = 8'(vrest);
    endtask

    task automatic set_rand();
        for (int n = 0; n < 8; n++) din[n] = 8'($urandom_range(255, 0));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        din_valid = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic idle(input int n);
        din_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        build_coef();
        for (int i = 0; i < 4; i++) begin
            h_val[i] = 0;
            h_idx[i] = 0;
        end
        m_cnt = 0;
        for (int k = 0; k < 8; k++) last_dat[k] = 0;
        rst = 1'b1;
        din_valid = 1'b0;
        set_col(128, 128);

        // Pin the reference against hand-computed values.
        chk("coef_0_0", coef[0][0], 1448);
        chk("coef_1_0", coef[1][0], 2009);
        chk("coef_2_1", coef[2][1], 784);
        chk("coef_7_7", coef[7][7], -400);
        for (int n = 0; n < 8; n++) px[n] = 255;
        chk("model_all255_x0", dct_k(px, 0), 359);
        px[0] = 255;
        for (int n = 1; n < 8; n++) px[n] = 128;
        chk("model_impulse_x2", dct_k(px, 2), 59);

        tick(); tick(); tick();
        rst = 1'b0;
        tick();
        chk("reset_col_idx", int'(col_idx), 0);
        chk("reset_dout_valid", int'(dout_valid), 0);

        // Single mid-grey column: exact 4-cycle latency, all-zero output.
        clear_log();
        set_col(128, 128);
        din_valid = 1'b1;
        tick();
        in_q.push_back(cyc);
        idle(8);
        chk("t1_count", log_cyc.size(), 1);
        if (log_cyc.size() == 1) begin
            chk("t1_latency", log_cyc[0] - in_q[0] + 1, 4);
            chk("t1_x0", log_d0[0], 0);
            chk("t1_nonzero_ac", log_nz[0], 0);
            chk("t1_col_idx", log_idx[0], 0);
            chk("t1_blk_start", log_blk[0], 1);
        end

        // White, black and impulse columns back to back.
        clear_log();
        din_valid = 1'b1;
        set_col(255, 255); tick();
        set_col(0, 0);     tick();
        set_col(255, 128); tick();
        idle(8);
        chk("t2_count", log_cyc.size(), 3);
        if (log_cyc.size() == 3) begin
            chk("white_x0", log_d0[0], 359);
            chk("white_ac_nz", log_nz[0], 0);
            chk("white_col_idx", log_idx[0], 1);
            chk("black_x0", log_d0[1], -362);
            chk("black_ac_nz", log_nz[1], 0);
            chk("impulse_x0", log_d0[2], 45);
            chk("impulse_x1", log_d1[2], 62);
            chk("impulse_col_idx", log_idx[2], 3);
        end

        // 16 back-to-back random columns.
        do_reset();
        clear_log();
        din_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            set_rand();
            tick();
        end
        idle(8);
        chk("burst_count", log_cyc.size(), 16);
        if (log_cyc.size() == 16) begin
            for (int i = 0; i < 16; i++) begin
                chk($sformatf("burst_cycle_%0d", i), log_cyc[i] - log_cyc[0], i);
                chk($sformatf("burst_idx_%0d", i), log_idx[i], i % 8);
                chk($sformatf("burst_blk_%0d", i), log_blk[i], (i % 8 == 0) ? 1 : 0);
            end
        end

        // Gapped input: output valids keep the input gap pattern, delayed.
        do_reset();
        clear_log();
        for (int i = 0; i < 13; i++) begin
            din_valid = (gap_pat[i] != 0);
            set_rand();
            tick();
            if (gap_pat[i] != 0) in_q.push_back(cyc);
        end
        idle(8);
        chk("gap_count", log_cyc.size(), in_q.size());
        if (log_cyc.size() == in_q.size()) begin
            for (int i = 0; i < in_q.size(); i++) begin
                chk($sformatf("gap_latency_%0d", i), log_cyc[i] - in_q[i] + 1, 4);
            end
            if (log_idx.size() > 3) chk("gap_idx_after_idle", log_idx[3], 3);
        end

        // Reset with three columns in flight, din_valid held high during reset.
        do_reset();
        clear_log();
        din_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_rand();
            tick();
        end
        rst = 1'b1;
        set_rand();
        tick();
        rst = 1'b0;
        idle(8);
        chk("flush_no_valid", log_cyc.size(), 0);
        set_col(200, 50);
        din_valid = 1'b1;
        tick();
        idle(6);
        chk("flush_next_count", log_cyc.size(), 1);
        if (log_cyc.size() == 1) begin
            chk("flush_next_idx", log_idx[0], 0);
            chk("flush_next_blk", log_blk[0], 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
